// File: rtl/hex_seq_pkg.sv
// ---------------------------------------------------------------------------
// hex_seq_pkg
//   Shared definitions for the HEX display sequencer:
//     seq_state_t   - sequencer FSM states
//     SEG_TABLE     - active-low g..a segment patterns for nibbles 0..F
//     SEG_BLANK     - code that turns every segment and the DP off
//     PIO_DATA_ADDR - word address of the PIO data register
// ---------------------------------------------------------------------------
package hex_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    // Packed so entry n is SEG_TABLE[n]; the first listed element is entry 15.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    localparam logic [7:0] SEG_BLANK     = 8'hFF;
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/hex_seg_encoder.sv
// ---------------------------------------------------------------------------
// hex_seg_encoder
//   Combinational nibble to seven-segment code, active-low.
//   Ports:
//     nibble_i - hex digit value 0..F
//     dp_i     - 1 lights the decimal point
//     blank_i  - 1 turns the whole digit off (wins over dp_i)
//     code_o   - {~dp, g, f, e, d, c, b, a}, all active-low
// ---------------------------------------------------------------------------
module hex_seg_encoder
    import hex_seq_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] code_o
);

    always_comb begin
        code_o = {~dp_i, SEG_TABLE[nibble_i]};
        if (blank_i) begin
            code_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/hex_display_sequencer.sv
// ---------------------------------------------------------------------------
// hex_display_sequencer
//   Avalon-MM write master for a bank of 8-bit seven-segment PIO slaves.
//   A request (value, dp mask, blank mask, force) is taken over a
//   valid/ready handshake; every digit whose code differs from the last
//   code written to it (or every digit, when forced) gets one single-cycle
//   write through its own chipselect.
//   Ports:
//     clk, reset     - system clock, asynchronous active-high reset
//     req_valid/ready- request handshake
//     req_value      - nibble i is shown on digit i
//     req_dp         - per-digit decimal point
//     req_blank      - per-digit blank
//     req_force      - write every digit regardless of the shadow
//     hex_cs         - one-hot chipselect, bit i selects PIO i
//     hex_write_n    - shared active-low write strobe
//     hex_address    - shared word address (PIO data register)
//     hex_writedata  - {24'b0, code}
//     busy           - request in progress
//     done           - one-cycle pulse when a request completes
// ---------------------------------------------------------------------------
module hex_display_sequencer
    import hex_seq_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_value,
    input  logic [7:0]            req_dp,
    input  logic [7:0]            req_blank,
    input  logic                  req_force,
    output logic [NUM_DIGITS-1:0] hex_cs,
    output logic                  hex_write_n,
    output logic [1:0]            hex_address,
    output logic [31:0]           hex_writedata,
    output logic                  busy,
    output logic                  done
);

    // Index must reach NUM_DIGITS (one past the last digit).
    localparam int IDX_W = 4;
    localparam int GAP_W = 4;

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [31:0]        value_q;
    logic [7:0]         dp_q;
    logic [7:0]         blank_q;
    logic               force_q;

    logic [7:0]         code_arr [NUM_DIGITS];
    logic [7:0]         shadow_q [NUM_DIGITS];
    logic [7:0]         cur_code;
    logic [7:0]         cur_shadow;

    logic [NUM_DIGITS-1:0] cs_q, cs_d;
    logic               write_n_q;
    logic [7:0]         wdata_q;

    logic               accept;
    logic               in_range;
    logic               wr_en;

    // Ready in FINISH too, so a held request follows done with no bubble.
    assign accept   = req_valid && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
    assign in_range = (idx_q < IDX_W'(NUM_DIGITS));

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            force_q <= 1'b0;
        end else if (accept) begin
            value_q <= req_value;
            dp_q    <= req_dp;
            blank_q <= req_blank;
            force_q <= req_force;
        end
    end

    // ------------------------------------------------------------------
    // Per-digit encoders and shadow registers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            hex_seg_encoder u_enc (
                .nibble_i (value_q[4*gi +: 4]),
                .dp_i     (dp_q[gi]),
                .blank_i  (blank_q[gi]),
                .code_o   (code_arr[gi])
            );

            // Mirrors what PIO gi currently holds; its reset value matches
            // the PIO reset value so an all-zero code needs no write.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    shadow_q[gi] <= 8'h00;
                end else if (wr_en && (idx_q == IDX_W'(gi))) begin
                    shadow_q[gi] <= cur_code;
                end
            end

            assign cs_d[gi] = wr_en && (idx_q == IDX_W'(gi));
        end
    endgenerate

    // Select the code and shadow of the digit currently being scanned.
    always_comb begin
        cur_code   = 8'h00;
        cur_shadow = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code   = code_arr[i];
                cur_shadow = shadow_q[i];
            end
        end
    end

    assign wr_en = (state_q == ST_SCAN) && in_range &&
                   (force_q || (cur_code != cur_shadow));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end

            ST_SCAN: begin
                busy = 1'b1;
                if (!in_range) begin
                    // One scan slot past the last digit lets the final
                    // strobe retire before done is raised.
                    state_d = ST_FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (wr_en && (GAP_CYCLES > 0)) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                    end
                end
            end

            ST_GAP: begin
                busy = 1'b1;
                if (gap_q == '0) begin
                    state_d = ST_SCAN;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            ST_FINISH: begin
                done      = 1'b1;
                req_ready = 1'b1;
                if (accept) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered Avalon strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q      <= '0;
            write_n_q <= 1'b1;
            wdata_q   <= 8'h00;
        end else begin
            cs_q      <= cs_d;
            write_n_q <= ~wr_en;
            if (wr_en) begin
                wdata_q <= cur_code;
            end
        end
    end

    assign hex_cs        = cs_q;
    assign hex_write_n   = write_n_q;
    assign hex_address   = PIO_DATA_ADDR;
    assign hex_writedata = {24'b0, wdata_q};

endmodule

// File: tb/tb_hex_display_sequencer.sv
module tb_hex_display_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Shared request fields, separate handshake/reset per DUT
    logic        a_reset, b_reset, a_valid, b_valid;
    logic [31:0] req_value;
    logic [7:0]  req_dp, req_blank;
    logic        req_force;

    logic        a_ready, a_wn, a_busy, a_done;
    logic [7:0]  a_cs;
    logic [1:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_ready, b_wn, b_busy, b_done;
    logic [7:0]  b_cs;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;

    hex_display_sequencer #(.NUM_DIGITS(8), .GAP_CYCLES(0)) u_dut_a (
        .clk(clk), .reset(a_reset), .req_valid(a_valid), .req_ready(a_ready),
        .req_value(req_value), .req_dp(req_dp), .req_blank(req_blank),
        .req_force(req_force), .hex_cs(a_cs), .hex_write_n(a_wn),
        .hex_address(a_addr), .hex_writedata(a_wdata), .busy(a_busy), .done(a_done)
    );

    hex_display_sequencer #(.NUM_DIGITS(8), .GAP_CYCLES(3)) u_dut_b (
        .clk(clk), .reset(b_reset), .req_valid(b_valid), .req_ready(b_ready),
        .req_value(req_value), .req_dp(req_dp), .req_blank(req_blank),
        .req_force(req_force), .hex_cs(b_cs), .hex_write_n(b_wn),
        .hex_address(b_addr), .hex_writedata(b_wdata), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Hand-entered segment table used to form expected codes
    function automatic logic [7:0] exp_code(input logic [3:0] nib, input logic dp, input logic bl);
        logic [6:0] seg [16];
        seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        if (bl) return 8'hFF;
        return {~dp, seg[nib]};
    endfunction

    // Codes for 32'h0123_4567, digit 0 first
    logic [7:0] exp1 [8] = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

    // Write monitors and bus invariants
    logic [7:0] a_wcs[$], a_wdat[$], b_wcs[$], b_wdat[$];
    int         a_wcyc[$], b_wcyc[$];

    always @(negedge clk) begin
        if (a_wn == 1'b0) begin
            a_wcs.push_back(a_cs); a_wdat.push_back(a_wdata[7:0]); a_wcyc.push_back(cyc);
        end
        if (b_wn == 1'b0) begin
            b_wcs.push_back(b_cs); b_wdat.push_back(b_wdata[7:0]); b_wcyc.push_back(cyc);
        end
        chk("a_onehot", 32'($onehot0(a_cs)), 32'd1);
        chk("b_onehot", 32'($onehot0(b_cs)), 32'd1);
        chk("a_wn_vs_cs", 32'(a_wn), 32'(a_cs == 8'h00));
        chk("b_wn_vs_cs", 32'(b_wn), 32'(b_cs == 8'h00));
        chk("a_addr", 32'(a_addr), 32'd0);
        chk("b_addr", 32'(b_addr), 32'd0);
        chk("a_wdata_hi", 32'(a_wdata[31:8]), 32'd0);
    end

    task automatic clr_q();
        a_wcs.delete(); a_wdat.delete(); a_wcyc.delete();
        b_wcs.delete(); b_wdat.delete(); b_wcyc.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_req(input bit which, input logic [31:0] v, input logic [7:0] dp,
                             input logic [7:0] bl, input logic f, output int acc);
        int n = 0;
        req_value = v; req_dp = dp; req_blank = bl; req_force = f;
        if (which) b_valid = 1'b1; else a_valid = 1'b1;
        while (((which ? b_ready : a_ready) !== 1'b1) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("accept", 32'((which ? b_ready : a_ready) === 1'b1), 32'd1);
        acc = cyc + 1;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        chk("busy_after_accept", 32'(which ? b_busy : a_busy), 32'd1);
        chk("ready_after_accept", 32'(which ? b_ready : a_ready), 32'd0);
    endtask

    // Latency = index of the first rising edge that sees done, counted from accept.
    task automatic wait_done(input bit which, input int acc, output int lat);
        int n = 0;
        lat = -1;
        while (n < 200) begin
            if ((which ? b_done : a_done) === 1'b1) begin
                lat = cyc + 1 - acc;
                break;
            end
            @(negedge clk); n++;
        end
    endtask

    task automatic run_req(input bit which, input logic [31:0] v, input logic [7:0] dp,
                           input logic [7:0] bl, input logic f, input int exp_wr,
                           input int exp_lat, output int acc);
        int lat, n;
        clr_q();
        start_req(which, v, dp, bl, f, acc);
        wait_done(which, acc, lat);
        chk("latency", 32'(lat), 32'(exp_lat));
        n = which ? b_wcs.size() : a_wcs.size();
        chk("write_count", 32'(n), 32'(exp_wr));
        $display("txn dut=%0d value=%h dp=%h blank=%h force=%0d writes=%0d latency=%0d",
                 which, v, dp, bl, f, n, lat);
        @(negedge clk);
    endtask

    task automatic chk_wr(input bit which, input int k, input logic [7:0] ecs,
                          input logic [7:0] edat, input int eoff, input int acc);
        logic [7:0] gcs = 8'h00, gdat = 8'h00;
        int goff = -1;
        if (!which && k < a_wcs.size()) begin
            gcs = a_wcs[k]; gdat = a_wdat[k]; goff = a_wcyc[k] - acc;
        end else if (which && k < b_wcs.size()) begin
            gcs = b_wcs[k]; gdat = b_wdat[k]; goff = b_wcyc[k] - acc;
        end
        chk($sformatf("wr%0d_cs", k), 32'(gcs), 32'(ecs));
        chk($sformatf("wr%0d_data", k), 32'(gdat), 32'(edat));
        chk($sformatf("wr%0d_offset", k), 32'(goff), 32'(eoff));
    endtask

    initial begin
        int acc, acc2, lat, n;
        logic [31:0] v1, v2, vb;

        a_reset = 1'b1; b_reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        req_value = '0; req_dp = '0; req_blank = '0; req_force = 1'b0;
        repeat (3) @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_cs", 32'(a_cs), 32'd0);
        chk("rst_wn", 32'(a_wn), 32'd1);
        chk("rst_wdata", a_wdata, 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_b_wdata", b_wdata, 32'd0);

        // Full write of 0123_4567
        run_req(0, 32'h0123_4567, 8'h00, 8'h00, 1'b0, 8, 10, acc);
        for (int k = 0; k < 8; k++) chk_wr(0, k, 8'(1 << k), exp1[k], k + 1, acc);

        // Identical request: no writes, done still pulses
        run_req(0, 32'h0123_4567, 8'h00, 8'h00, 1'b0, 0, 10, acc);

        // Forced: all written again
        run_req(0, 32'h0123_4567, 8'h00, 8'h00, 1'b1, 8, 10, acc);
        for (int k = 0; k < 8; k++) chk_wr(0, k, 8'(1 << k), exp1[k], k + 1, acc);

        // Only nibble 3 changes to F
        run_req(0, 32'h0123_F567, 8'h00, 8'h00, 1'b0, 1, 10, acc);
        chk_wr(0, 0, 8'h08, 8'h8E, 4, acc);

        // After reset, digit 0 = 8 with dp encodes to 00 = reset shadow
        a_reset = 1'b1; @(negedge clk); a_reset = 1'b0; @(negedge clk);
        run_req(0, 32'h0000_0008, 8'h01, 8'h00, 1'b0, 7, 10, acc);
        for (int k = 0; k < 7; k++) chk_wr(0, k, 8'(1 << (k + 1)), 8'hC0, k + 2, acc);

        // Back-to-back: second request held high during the first
        clr_q();
        v1 = 32'h89AB_CDEF; v2 = 32'h89AB_CDE0;
        req_value = v1; req_dp = 8'h00; req_blank = 8'h00; req_force = 1'b0;
        a_valid = 1'b1;
        chk("b2b_ready_first", 32'(a_ready), 32'd1);
        acc = cyc + 1;
        @(negedge clk);
        req_value = v2;
        n = 0;
        while (a_done !== 1'b1 && n < 100) begin
            chk("b2b_ready_low", 32'(a_ready), 32'd0);
            @(negedge clk); n++;
        end
        chk("b2b_lat1", 32'(cyc + 1 - acc), 32'd10);
        chk("b2b_ready_at_done", 32'(a_ready), 32'd1);
        acc2 = cyc + 1;
        @(negedge clk);
        a_valid = 1'b0;
        chk("b2b_second_busy", 32'(a_busy), 32'd1);
        chk("b2b_no_bubble", 32'(acc2 - acc), 32'd10);
        wait_done(0, acc2, lat);
        chk("b2b_lat2", 32'(lat), 32'd10);
        chk("b2b_writes", 32'(a_wcs.size()), 32'd9);
        for (int k = 0; k < 8; k++)
            chk_wr(0, k, 8'(1 << k), exp_code(v1[4*k +: 4], 1'b0, 1'b0), k + 1, acc);
        chk_wr(0, 8, 8'h01, 8'hC0, 1, acc2);
        $display("txn dut=0 back-to-back value=%h then %h writes=%0d", v1, v2, a_wcs.size());
        @(negedge clk);

        // Reset in the middle of digit 4's write
        clr_q();
        start_req(0, 32'h0123_4567, 8'h00, 8'h00, 1'b0, acc);
        n = 0;
        while (a_cs !== 8'h10 && n < 20) begin @(negedge clk); n++; end
        chk("mid_digit4_seen", 32'(a_cs), 32'h10);
        a_reset = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(a_cs), 32'd0);
        chk("mid_rst_wn", 32'(a_wn), 32'd1);
        chk("mid_rst_ready", 32'(a_ready), 32'd1);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_wdata", a_wdata, 32'd0);
        $display("txn dut=0 reset during digit 4 write");
        @(negedge clk); a_reset = 1'b0; @(negedge clk);
        run_req(0, 32'h0123_4567, 8'h00, 8'h00, 1'b0, 8, 10, acc);
        for (int k = 0; k < 8; k++) chk_wr(0, k, 8'(1 << k), exp1[k], k + 1, acc);

        // GAP_CYCLES=3, upper four digits blanked (blank overrides dp)
        vb = 32'h0123_4567;
        run_req(1, vb, 8'hFF, 8'hF0, 1'b0, 8, 34, acc);
        for (int k = 0; k < 8; k++)
            chk_wr(1, k, 8'(1 << k), exp_code(vb[4*k +: 4], 1'b1, k >= 4), 1 + 4 * k, acc);
        chk("gap_blank_d4", 32'(b_wdat.size() > 4 ? b_wdat[4] : 8'h00), 32'hFF);
        run_req(1, vb, 8'hFF, 8'hF0, 1'b0, 0, 10, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
